wb_trace_buf: RTL

WB_TRACE_BUF -- requirements
Module: wb_trace_buf

---
 rtl/wb_trace_buf.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/wb_trace_buf.sv
// wb_trace_buf: write-back trace FIFO with retire counter and an optional end-of-test checker.
//
// Each retiring instruction (wb_valid) is captured as {pc, rf_wen, rf_waddr, rf_wdata}
// into a DEPTH-entry FIFO. The head entry is presented on trace_* with a valid/ready
// handshake. A push into a full FIFO that is not popped in the same cycle is dropped,
// and the sticky overflow flag records it. retire_cnt counts every retirement,
// including dropped ones.
//
// Build option: define WB_TRACE_CHECK_EN to include the end-of-test checker.
// The checker shadows GPR CHECK_REG. When END_PC retires, it raises sim_done and
// reports whether the shadow equals CHECK_VAL. Without the macro, sim_done and
// sim_pass are tied to 0 and no shadow register exists.

module wb_trace_buf #(
  parameter int unsigned DEPTH     = 8,            // power of two, 2..64
  parameter logic [31:0] END_PC    = 32'h1c00_0010,
  parameter int unsigned CHECK_REG = 5,
  parameter logic [31:0] CHECK_VAL = 32'h0000_005a
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        wb_valid,
  input  logic [31:0] wb_pc,
  input  logic        wb_rf_wen,
  input  logic [4:0]  wb_rf_waddr,
  input  logic [31:0] wb_rf_wdata,

  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] trace_pc,
  output logic        trace_wen,
  output logic [4:0]  trace_waddr,
  output logic [31:0] trace_wdata,

  output logic        overflow,
  output logic [31:0] retire_cnt,
  output logic        sim_done,
  output logic        sim_pass
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef struct packed {
    logic [31:0] pc;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } trace_entry_t;

  // ---------------------------------------------------------------------------
  // FIFO storage and pointers
  // ---------------------------------------------------------------------------
  trace_entry_t mem_q [DEPTH];

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         overflow_q, overflow_d;
  logic [31:0]  retire_cnt_q, retire_cnt_d;

  logic         fifo_empty;
  logic         fifo_full;
  logic         push;
  logic         pop;
  trace_entry_t entry_in;
  trace_entry_t head;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign pop  = !fifo_empty && trace_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push = wb_valid && (!fifo_full || pop);

  // Writes to r0 have no architectural effect, so they are recorded with wen cleared.
  assign entry_in = '{
    pc:    wb_pc,
    wen:   wb_rf_wen && (wb_rf_waddr != 5'd0),
    waddr: wb_rf_waddr,
    wdata: wb_rf_wdata
  };

  // Next-state logic for the pointers, the overflow flag and the retire counter.
  always_comb begin
    // NOTE: every signal assigned here gets a default first. Without that, a path that
    // skips the assignment would infer a latch.
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    overflow_d   = overflow_q;
    retire_cnt_d = retire_cnt_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (wb_valid && !push) begin
      overflow_d = 1'b1;
    end
    if (wb_valid) begin
      retire_cnt_d = retire_cnt_q + 32'd1;
    end
  end

  // FIFO control state register. Reset drops every buffered entry by equalising the pointers.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments. All flops then update together
    // at the edge, independent of statement order.
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      overflow_q   <= 1'b0;
      retire_cnt_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      overflow_q   <= overflow_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // Entry storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset. Entries are only read when the pointers say
    // they are valid, so clearing them would add reset fan-out and change nothing.
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= entry_in;
    end
  end

  assign head        = mem_q[rd_ptr_q[AW-1:0]];
  assign trace_valid = !fifo_empty;
  assign trace_pc    = head.pc;
  assign trace_wen   = head.wen;
  assign trace_waddr = head.waddr;
  assign trace_wdata = head.wdata;
  assign overflow    = overflow_q;
  assign retire_cnt  = retire_cnt_q;

  // ---------------------------------------------------------------------------
  // End-of-test checker
  // ---------------------------------------------------------------------------
`ifdef WB_TRACE_CHECK_EN
  typedef enum logic {
    CHK_RUN  = 1'b0,
    CHK_DONE = 1'b1
  } chk_state_e;

  localparam logic [4:0] CHECK_IDX = CHECK_REG[4:0];

  chk_state_e  chk_state_q, chk_state_d;
  logic [31:0] shadow_q, shadow_d;
  logic        pass_q, pass_d;

  // Checker next-state logic. The verdict includes a write that retires together with END_PC.
  always_comb begin
    chk_state_d = chk_state_q;
    shadow_d    = shadow_q;
    pass_d      = pass_q;

    if (chk_state_q == CHK_RUN) begin
      if (wb_valid && wb_rf_wen && (wb_rf_waddr == CHECK_IDX) && (CHECK_IDX != 5'd0)) begin
        shadow_d = wb_rf_wdata;
      end
      if (wb_valid && (wb_pc == END_PC)) begin
        chk_state_d = CHK_DONE;
        pass_d      = (shadow_d == CHECK_VAL);
      end
    end
  end

  // Checker state register. DONE is absorbing until reset, which freezes the verdict.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chk_state_q <= CHK_RUN;
      shadow_q    <= '0;
      pass_q      <= 1'b0;
    end else begin
      chk_state_q <= chk_state_d;
      shadow_q    <= shadow_d;
      pass_q      <= pass_d;
    end
  end

  assign sim_done = (chk_state_q == CHK_DONE);
  assign sim_pass = pass_q;
`else
  // The checker configuration parameters have no function in this build.
  logic unused_check_cfg;
  assign unused_check_cfg = ^{END_PC, CHECK_VAL, CHECK_REG[4:0]};

  assign sim_done = 1'b0;
  assign sim_pass = 1'b0;
`endif

endmodule
